rng_pool_ctrl: RTL and testbench

// Sequencer/consumer downstream of random_num_gen: issues enable_p, waits for done_p, captures the NBITS pool.

---
 rtl/rng_pool_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_rng_pool_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_pool_ctrl.sv
// rng_pool_ctrl: sequencer and consumer for random_num_gen.
// Starts the generator with a one-cycle gen_enable_p, waits for gen_done_p, captures the
// NBITS pool, health-checks it and serves accepted pools as WORD-bit words on a valid/ready
// port (word 0 = pool[WORD-1:0] first). Refills automatically while req_en is high. Repeated
// rejects or timeouts park the block in a sticky FAIL state until clr_fail.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_en                   level, keep producing words
//   clr_fail                 pulse, leave FAIL
//   cfg_bypass, cfg_maxbits  generator settings, latched on IDLE->REQ
//   gen_enable_p             one-cycle start pulse to generator
//   gen_bypass, gen_maxbits  latched generator settings
//   gen_done_p, gen_y        generator completion pulse and pool
//   rd_valid, rd_ready       output handshake
//   rd_data                  output word
//   busy                     not IDLE and not FAIL
//   health_fail              in FAIL
module rng_pool_ctrl #(
  parameter int unsigned NBITS      = 256,
  parameter int unsigned WORD       = 32,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned FAIL_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_en,
  input  logic             clr_fail,
  input  logic             cfg_bypass,
  input  logic [11:0]      cfg_maxbits,
  output logic             gen_enable_p,
  output logic             gen_bypass,
  output logic [11:0]      gen_maxbits,
  input  logic             gen_done_p,
  input  logic [NBITS-1:0] gen_y,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WORD-1:0]  rd_data,
  output logic             busy,
  output logic             health_fail
);

  localparam int unsigned NWORDS = NBITS / WORD;
  localparam int unsigned IdxW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned WcW    = $clog2(TIMEOUT);
  localparam int unsigned FcW    = $clog2(FAIL_LIMIT + 1);

  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NWORDS - 1);
  localparam logic [WcW-1:0]  WaitLast   = WcW'(TIMEOUT - 1);
  localparam logic [FcW-1:0]  FailLimitC = FcW'(FAIL_LIMIT);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StCheck,
    StServe,
    StFail
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] pool_q, pool_d;
  logic [NBITS-1:0] prev_pool_q, prev_pool_d;
  logic [IdxW-1:0]  word_idx_q, word_idx_d;
  logic [FcW-1:0]   fail_cnt_q, fail_cnt_d;
  logic [WcW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             bypass_q, bypass_d;
  logic [11:0]      maxbits_q, maxbits_d;

  logic [FcW-1:0] fail_inc;
  logic           fail_hit;
  logic           pool_bad;

  // Saturating increment; reaching the limit is what sends us to FAIL.
  assign fail_inc = (fail_cnt_q == FailLimitC) ? fail_cnt_q : fail_cnt_q + FcW'(1);
  assign fail_hit = (fail_inc == FailLimitC);
  assign pool_bad = (pool_q == prev_pool_q) || (pool_q == '0) || (&pool_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pool_q      <= '0;
      prev_pool_q <= '0;
      word_idx_q  <= '0;
      fail_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      bypass_q    <= 1'b0;
      maxbits_q   <= '0;
    end else begin
      state_q     <= state_d;
      pool_q      <= pool_d;
      prev_pool_q <= prev_pool_d;
      word_idx_q  <= word_idx_d;
      fail_cnt_q  <= fail_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      bypass_q    <= bypass_d;
      maxbits_q   <= maxbits_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    pool_d      = pool_q;
    prev_pool_d = prev_pool_q;
    word_idx_d  = word_idx_q;
    fail_cnt_d  = fail_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    bypass_d    = bypass_q;
    maxbits_d   = maxbits_q;
    unique case (state_q)
      StIdle: begin
        if (req_en) begin
          state_d   = StReq;
          bypass_d  = cfg_bypass;
          maxbits_d = cfg_maxbits;
        end
      end
      StReq: begin
        wait_cnt_d = '0;
        state_d    = req_en ? StWait : StIdle;
      end
      StWait: begin
        // Dropping req_en wins; a done pulse arriving later lands outside WAIT and is ignored.
        if (!req_en) begin
          state_d = StIdle;
        end else if (gen_done_p) begin
          pool_d  = gen_y;
          state_d = StCheck;
        end else if (wait_cnt_q == WaitLast) begin
          fail_cnt_d = fail_inc;
          state_d    = fail_hit ? StFail : StReq;
        end else begin
          wait_cnt_d = wait_cnt_q + WcW'(1);
        end
      end
      StCheck: begin
        if (pool_bad) begin
          fail_cnt_d = fail_inc;
          state_d    = fail_hit ? StFail : StReq;
        end else begin
          fail_cnt_d  = '0;
          prev_pool_d = pool_q;
          word_idx_d  = '0;
          state_d     = StServe;
        end
      end
      StServe: begin
        if (rd_ready) begin
          word_idx_d = word_idx_q + IdxW'(1);
          if (word_idx_q == LastIdx) begin
            state_d = req_en ? StReq : StIdle;
          end
        end else if (!req_en) begin
          state_d = StIdle;
        end
      end
      StFail: begin
        if (clr_fail) begin
          fail_cnt_d = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs, decoded from state and registers only
  always_comb begin
    gen_enable_p = (state_q == StReq);
    rd_valid     = (state_q == StServe);
    health_fail  = (state_q == StFail);
    busy         = (state_q != StIdle) && (state_q != StFail);
    gen_bypass   = bypass_q;
    gen_maxbits  = maxbits_q;
    rd_data      = '0;
    for (int k = 0; k < int'(NWORDS); k++) begin
      if (word_idx_q == IdxW'(k)) begin
        rd_data = pool_q[k*WORD +: WORD];
      end
    end
  end

endmodule

// File: tb/tb_rng_pool_ctrl.sv
// Bench for rng_pool_ctrl. Instance "dut" (default parameters) is paired with a behavioural
// generator model; instance "dto" (TIMEOUT=16) is driven by hand for timeout and pool checks.
module tb_rng_pool_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_bypass;
  logic [11:0]  cfg_maxbits;

  // Main instance
  logic         req_en, clr_fail, rd_ready;
  logic         d_enable, d_bypass, d_valid, d_busy, d_fail;
  logic [11:0]  d_maxbits;
  logic [31:0]  d_data;
  logic         gen_done;
  logic [255:0] gen_y;

  // Timeout instance
  logic         t_req_en, t_clr_fail, t_ready, t_done;
  logic [255:0] t_y;
  logic         t_enable, t_bypass, t_valid, t_busy, t_fail;
  logic [11:0]  t_maxbits;
  logic [31:0]  t_data;

  // Generator model state
  int           mode = 0;          // 0 incrementing pools, 1 stuck pool
  int           mcnt = 0;
  logic         m_done = 1'b0;
  logic [255:0] m_y = '0;
  logic [7:0]   next_base = 8'h00;
  logic         inj_done = 1'b0;
  logic [255:0] inj_y = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign gen_done = m_done | inj_done;
  assign gen_y    = inj_done ? inj_y : m_y;

  rng_pool_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_en(req_en), .clr_fail(clr_fail),
    .cfg_bypass(cfg_bypass), .cfg_maxbits(cfg_maxbits),
    .gen_enable_p(d_enable), .gen_bypass(d_bypass), .gen_maxbits(d_maxbits),
    .gen_done_p(gen_done), .gen_y(gen_y),
    .rd_valid(d_valid), .rd_ready(rd_ready), .rd_data(d_data),
    .busy(d_busy), .health_fail(d_fail)
  );

  rng_pool_ctrl #(.TIMEOUT(16)) dto (
    .clk(clk), .rst_n(rst_n), .req_en(t_req_en), .clr_fail(t_clr_fail),
    .cfg_bypass(cfg_bypass), .cfg_maxbits(cfg_maxbits),
    .gen_enable_p(t_enable), .gen_bypass(t_bypass), .gen_maxbits(t_maxbits),
    .gen_done_p(t_done), .gen_y(t_y),
    .rd_valid(t_valid), .rd_ready(t_ready), .rd_data(t_data),
    .busy(t_busy), .health_fail(t_fail)
  );

  function automatic logic [255:0] make_pool(input logic [7:0] base);
    logic [255:0] p;
    for (int i = 0; i < 32; i++) p[i*8 +: 8] = base + 8'(i);
    return p;
  endfunction

  function automatic logic [31:0] word_of(input logic [7:0] base, input int j);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[b*8 +: 8] = base + 8'(4*j + b);
    return w;
  endfunction

  // Generator model: done pulse 50 cycles after an enable pulse.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      mcnt = 0;
    end else if (d_enable) begin
      mcnt = 50;
    end else if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) begin
        m_done = 1'b1;
        if (mode == 1) begin
          m_y = {32{8'h5A}};
        end else begin
          m_y = make_pool(next_base);
          next_base = next_base + 8'h20;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!d_valid && n < 300) begin
      step();
      n++;
    end
    chk(name, 64'(d_valid), 64'(1));
  endtask

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
  } bp_vec_t;

  bp_vec_t      bp_tab[16];
  logic [255:0] t_pools[3];
  logic         t_acc[3];

  initial begin
    int n;
    int done_at;
    int ecnt;
    int et[4];
    logic flag;

    // Backpressure: ready 0,1,0,1...; word j shown twice, transferred on the odd cycle.
    for (int i = 0; i < 16; i++) begin
      bp_tab[i].ready     = (i % 2 == 1);
      bp_tab[i].exp_valid = 1'b1;
      bp_tab[i].exp_data  = word_of(8'h20, i / 2);
    end
    t_pools[0] = '0;               t_acc[0] = 1'b0;
    t_pools[1] = '1;               t_acc[1] = 1'b0;
    t_pools[2] = make_pool(8'h40); t_acc[2] = 1'b1;

    rst_n = 1'b0; req_en = 1'b0; clr_fail = 1'b0; rd_ready = 1'b0;
    cfg_bypass = 1'b0; cfg_maxbits = '0;
    t_req_en = 1'b0; t_clr_fail = 1'b0; t_ready = 1'b0; t_done = 1'b0; t_y = '0;
    repeat (3) step();

    // Reset state
    chk("rst_enable", 64'(d_enable), 64'(0));
    chk("rst_valid", 64'(d_valid), 64'(0));
    chk("rst_busy", 64'(d_busy), 64'(0));
    chk("rst_fail", 64'(d_fail), 64'(0));
    chk("rst_cfg", {51'(0), d_bypass, d_maxbits}, 64'(0));
    chk("rst_data", 64'(d_data), 64'(0));
    chk("rst_t_outs", {t_enable, t_valid, t_busy, t_fail, t_bypass, t_maxbits, t_data},
        64'(0));
    rst_n = 1'b1;
    step();

    // Normal flow
    cfg_bypass = 1'b1; cfg_maxbits = 12'h5A5; req_en = 1'b1;
    chk("idle_no_enable", 64'(d_enable), 64'(0));
    step();
    chk("req_enable", 64'(d_enable), 64'(1));
    chk("req_cfg", {51'(0), d_bypass, d_maxbits}, {51'(0), 1'b1, 12'h5A5});
    chk("req_busy", 64'(d_busy), 64'(1));
    cfg_bypass = 1'b0; cfg_maxbits = 12'h111;
    step();
    chk("wait_enable_low", 64'(d_enable), 64'(0));
    n = 0; done_at = -1;
    while (!d_valid && n < 200) begin
      if (gen_done && done_at < 0) done_at = n;
      step();
      n++;
    end
    chk("normal_valid", 64'(d_valid), 64'(1));
    // done sampled at edge k (CHECK), rd_valid visible after edge k+1 (SERVE)
    chk("done_to_valid", 64'(n - done_at), 64'(1));
    rd_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("normal_data", {31'(0), d_valid, d_data}, {31'(0), 1'b1, word_of(8'h00, j)});
      step();
    end
    rd_ready = 1'b0;
    chk("refill_enable", 64'(d_enable), 64'(1));
    chk("cfg_hold", {51'(0), d_bypass, d_maxbits}, {51'(0), 1'b1, 12'h5A5});

    // Backpressure
    wait_valid("bp_wait");
    for (int i = 0; i < 16; i++) begin
      rd_ready = bp_tab[i].ready;
      chk("bp_vec", {31'(0), d_valid, d_data}, {31'(0), bp_tab[i].exp_valid, bp_tab[i].exp_data});
      step();
    end
    rd_ready = 1'b0;
    chk("bp_done_refill", {62'(0), d_valid, d_enable}, {62'(0), 1'b0, 1'b1});

    // Drop req_en in REQ; the resulting done pulse arrives in IDLE and is ignored
    req_en = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (d_valid || d_busy) flag = 1'b1;
    end
    chk("late_done_idle", 64'(flag), 64'(0));

    // Abort after words 0..2
    req_en = 1'b1;
    step();
    wait_valid("abort_wait");
    rd_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("abort_data", 64'(d_data), 64'(word_of(8'h60, j)));
      step();
    end
    rd_ready = 1'b0; req_en = 1'b0;
    chk("abort_word3", {31'(0), d_valid, d_data}, {31'(0), 1'b1, word_of(8'h60, 3)});
    step();
    chk("abort_idle", {62'(0), d_valid, d_busy}, 64'(0));
    req_en = 1'b1;
    step();
    chk("abort_reissue", 64'(d_enable), 64'(1));
    chk("abort_cfg", 64'(d_maxbits), 64'(12'h111));
    wait_valid("abort_wait2");
    chk("abort_restart", 64'(d_data), 64'(word_of(8'h80, 0)));
    req_en = 1'b0;
    step();

    // Reset during WAIT
    req_en = 1'b1;
    step(); step(); step();
    chk("pre_rst_wait_busy", 64'(d_busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_wait_outs", {d_enable, d_bypass, d_maxbits, d_valid, d_busy, d_fail, d_data},
        64'(0));
    req_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    inj_y = make_pool(8'h10); inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (d_valid || d_busy || d_enable) flag = 1'b1;
      step();
    end
    chk("rst_late_done", 64'(flag), 64'(0));
    cfg_maxbits = 12'hABC; cfg_bypass = 1'b1; req_en = 1'b1;
    step();
    chk("rst_new_cfg", {50'(0), d_enable, d_bypass, d_maxbits}, {50'(0), 2'b11, 12'hABC});

    // Reset during SERVE
    wait_valid("serve_wait");
    chk("serve_data", 64'(d_data), 64'(word_of(8'hA0, 0)));
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_serve_outs", {d_enable, d_bypass, d_maxbits, d_valid, d_busy, d_fail, d_data},
        64'(0));
    req_en = 1'b0;
    step();
    rst_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (d_valid || d_enable) flag = 1'b1;
    end
    chk("rst_serve_quiet", 64'(flag), 64'(0));

    // Stuck source
    mode = 1; req_en = 1'b1;
    step();
    wait_valid("stuck_wait");
    rd_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("stuck_pool1", 64'(d_data), 64'(32'h5A5A5A5A));
      step();
    end
    rd_ready = 1'b0;
    n = 0; ecnt = 0; flag = 1'b0;
    while (!d_fail && n < 400) begin
      if (d_enable) ecnt++;
      if (d_valid) flag = 1'b1;
      step();
      n++;
    end
    chk("stuck_fail", 64'(d_fail), 64'(1));
    chk("stuck_enables", 64'(ecnt), 64'(3));
    chk("stuck_no_valid", 64'(flag), 64'(0));
    flag = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (d_enable || d_valid || d_busy || !d_fail) flag = 1'b1;
    end
    chk("fail_sticky", 64'(flag), 64'(0));
    clr_fail = 1'b1;
    step();
    clr_fail = 1'b0;
    chk("clr_fail_idle", {62'(0), d_fail, d_busy}, 64'(0));
    req_en = 1'b0;
    step();

    // Timeout (TIMEOUT=16, no done)
    t_req_en = 1'b1;
    step();
    n = 0; ecnt = 0;
    while (!t_fail && n < 200) begin
      if (t_enable) begin
        if (ecnt < 4) et[ecnt] = n;
        ecnt++;
      end
      step();
      n++;
    end
    chk("to_fail", 64'(t_fail), 64'(1));
    chk("to_pulses", 64'(ecnt), 64'(3));
    chk("to_gap1", 64'(et[1] - et[0]), 64'(17));
    chk("to_gap2", 64'(et[2] - et[1]), 64'(17));
    t_clr_fail = 1'b1; t_req_en = 1'b0;
    step();
    t_clr_fail = 1'b0;
    chk("to_clr", {62'(0), t_fail, t_busy}, 64'(0));

    // Pool health: all-zero and all-one rejected, good pool accepted
    t_req_en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("hc_req", 64'(t_enable), 64'(1));
      step();
      t_done = 1'b1; t_y = t_pools[i];
      step();
      t_done = 1'b0;
      step();
      chk("hc_result", {62'(0), t_valid, t_enable}, {62'(0), t_acc[i], ~t_acc[i]});
    end
    chk("hc_data", 64'(t_data), 64'(32'h43424140));
    t_req_en = 1'b0;
    step();
    chk("hc_abort", 64'(t_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
